// File: rtl/id_exe_stage_reg_pkg.sv
// Shared definitions for the ID/EXE pipeline register: datapath width,
// ALU command encodings, shift types, flag indices and field-group structs.
package id_exe_stage_reg_pkg;

  localparam int REGISTER_LEN = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // ALU commands (several opcodes share an encoding)
  localparam int EXE_CMD_LEN = 4;
  localparam logic [EXE_CMD_LEN-1:0] EXE_MOV = 4'b0001;
  localparam logic [EXE_CMD_LEN-1:0] EXE_MVN = 4'b1001;
  localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = 4'b0010;
  localparam logic [EXE_CMD_LEN-1:0] EXE_ADC = 4'b0011;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = 4'b0100;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SBC = 4'b0101;
  localparam logic [EXE_CMD_LEN-1:0] EXE_AND = 4'b0110;
  localparam logic [EXE_CMD_LEN-1:0] EXE_ORR = 4'b0111;
  localparam logic [EXE_CMD_LEN-1:0] EXE_EOR = 4'b1000;
  localparam logic [EXE_CMD_LEN-1:0] EXE_CMP = 4'b0100;
  localparam logic [EXE_CMD_LEN-1:0] EXE_TST = 4'b0110;
  localparam logic [EXE_CMD_LEN-1:0] EXE_LDR = 4'b0010;
  localparam logic [EXE_CMD_LEN-1:0] EXE_STR = 4'b0010;

  // Shift-type encodings used by the Val2 generator
  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  // NZCV bit positions in the status nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Datapath group: pc, val_rn, val_rm, shift_operand, signed_imm_24
  localparam int DATA_W = 3*REGISTER_LEN + 12 + 24;

  typedef struct packed {
    logic                   valid;
    logic                   immd;
    logic                   b;
    logic                   s;
    logic                   wb_en;
    logic                   mem_r_en;
    logic                   mem_w_en;
    logic [EXE_CMD_LEN-1:0] exe_cmd;
    logic [3:0]             status;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] dest;
    logic [3:0] src1;
    logic [3:0] src2;
  } regs_t;

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// ID -> EXE bus: decoded instruction from ID and its registered copy to EXE.
interface id_exe_stage_reg_if;
  import id_exe_stage_reg_pkg::*;

  logic                    valid_in, valid_out;
  logic [REGISTER_LEN-1:0] pc_in, pc_out;
  logic [REGISTER_LEN-1:0] val_rn_in, val_rn_out;
  logic [REGISTER_LEN-1:0] val_rm_in, val_rm_out;
  logic [11:0]             shift_operand_in, shift_operand_out;
  logic [23:0]             signed_imm_24_in, signed_imm_24_out;
  logic                    immd_in, immd_out;
  logic                    b_in, b_out;
  logic                    s_in, s_out;
  logic                    wb_en_in, wb_en_out;
  logic                    mem_r_en_in, mem_r_en_out;
  logic                    mem_w_en_in, mem_w_en_out;
  logic [EXE_CMD_LEN-1:0]  exe_cmd_in, exe_cmd_out;
  logic [3:0]              dest_in, dest_out;
  logic [3:0]              src1_in, src1_out;
  logic [3:0]              src2_in, src2_out;
  logic [3:0]              status_in, status_out;
  logic                    mem_cmd_out;

  // ID side drives the *_in fields and may observe the stage outputs
  modport master (
    output valid_in, pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
           immd_in, b_in, s_in, wb_en_in, mem_r_en_in, mem_w_en_in, exe_cmd_in,
           dest_in, src1_in, src2_in, status_in,
    input  valid_out, pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm_24_out,
           immd_out, b_out, s_out, wb_en_out, mem_r_en_out, mem_w_en_out, exe_cmd_out,
           dest_out, src1_out, src2_out, status_out, mem_cmd_out
  );

  // The pipeline register itself
  modport slave (
    input  valid_in, pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
           immd_in, b_in, s_in, wb_en_in, mem_r_en_in, mem_w_en_in, exe_cmd_in,
           dest_in, src1_in, src2_in, status_in,
    output valid_out, pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm_24_out,
           immd_out, b_out, s_out, wb_en_out, mem_r_en_out, mem_w_en_out, exe_cmd_out,
           dest_out, src1_out, src2_out, status_out, mem_cmd_out
  );
endinterface

// File: rtl/id_exe_stage_reg_pipe_field_reg.sv
// One group of pipeline flops: hold when !en, zero on clr, else load d.
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold beats clear so a frozen stage keeps its instruction through a flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (en)  q <= clr ? '0 : d;
  end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with freeze/flush and optional hazard counters.
// Define ID_EXE_STATS_EN to build the stall/bubble statistics counters;
// otherwise stall_cnt/bubble_cnt are tied to zero.
module id_exe_stage_reg
  import id_exe_stage_reg_pkg::*;
#(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              stats_clr,
  id_exe_stage_reg_if.slave bus,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bubble_cnt
);

  logic [DATA_W-1:0] data_d, data_q;
  ctrl_t             ctrl_d, ctrl_q;
  regs_t             regs_d, regs_q;

  assign data_d = {bus.pc_in, bus.val_rn_in, bus.val_rm_in,
                   bus.shift_operand_in, bus.signed_imm_24_in};

  assign ctrl_d = '{valid:    bus.valid_in,
                    immd:     bus.immd_in,
                    b:        bus.b_in,
                    s:        bus.s_in,
                    wb_en:    bus.wb_en_in,
                    mem_r_en: bus.mem_r_en_in,
                    mem_w_en: bus.mem_w_en_in,
                    exe_cmd:  bus.exe_cmd_in,
                    status:   bus.status_in};

  assign regs_d = '{dest: bus.dest_in, src1: bus.src1_in, src2: bus.src2_in};

  pipe_field_reg #(.W(DATA_W)) u_data (
    .clk(clk), .rst(rst), .en(!freeze), .clr(flush), .d(data_d), .q(data_q)
  );

  pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl (
    .clk(clk), .rst(rst), .en(!freeze), .clr(flush), .d(ctrl_d), .q(ctrl_q)
  );

  pipe_field_reg #(.W($bits(regs_t))) u_regs (
    .clk(clk), .rst(rst), .en(!freeze), .clr(flush), .d(regs_d), .q(regs_q)
  );

  assign {bus.pc_out, bus.val_rn_out, bus.val_rm_out,
          bus.shift_operand_out, bus.signed_imm_24_out} = data_q;

  assign bus.valid_out    = ctrl_q.valid;
  assign bus.immd_out     = ctrl_q.immd;
  assign bus.b_out        = ctrl_q.b;
  assign bus.s_out        = ctrl_q.s;
  assign bus.wb_en_out    = ctrl_q.wb_en;
  assign bus.mem_r_en_out = ctrl_q.mem_r_en;
  assign bus.mem_w_en_out = ctrl_q.mem_w_en;
  assign bus.exe_cmd_out  = ctrl_q.exe_cmd;
  assign bus.status_out   = ctrl_q.status;
  assign bus.dest_out     = regs_q.dest;
  assign bus.src1_out     = regs_q.src1;
  assign bus.src2_out     = regs_q.src2;

  // Built only from registered bits, so no input-to-output path
  assign bus.mem_cmd_out = ctrl_q.mem_r_en | ctrl_q.mem_w_en;

`ifdef ID_EXE_STATS_EN
  logic bubble_evt;
  assign bubble_evt = !freeze && (flush || !bus.valid_in);

  // Stall counter: one count per frozen edge, saturating; clear has priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         stall_cnt <= '0;
    else if (stats_clr)               stall_cnt <= '0;
    else if (freeze && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end

  // Bubble counter: flushed or empty captures, saturating; clear has priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              bubble_cnt <= '0;
    else if (stats_clr)                    bubble_cnt <= '0;
    else if (bubble_evt && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
  end
`else
  logic stats_clr_unused;
  assign stats_clr_unused = stats_clr;
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: directed plan steps followed by
// randomized freeze/flush/capture traffic against a field-level model.
module tb_id_exe_stage_reg;
  import id_exe_stage_reg_pkg::*;

  localparam int SW = 4;
  localparam logic [SW-1:0] SAT = {SW{1'b1}};

  typedef struct packed {
    logic [31:0] pc, val_rn, val_rm;
    logic [11:0] shop;
    logic [23:0] imm24;
    logic        valid, immd, b, s, wb, mr, mw;
    logic [3:0]  cmd, dest, src1, src2, status;
  } f_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic freeze = 1'b0, flush = 1'b0, stats_clr = 1'b0;
  logic [SW-1:0] stall_cnt, bubble_cnt;

  id_exe_stage_reg_if bus();

  id_exe_stage_reg #(.STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .stats_clr(stats_clr),
    .bus(bus.slave), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  f_t m;                 // model: what EXE should currently see
  logic [SW-1:0] m_stall, m_bub;

  function automatic f_t get_out();
    f_t v;
    v.pc = bus.pc_out; v.val_rn = bus.val_rn_out; v.val_rm = bus.val_rm_out;
    v.shop = bus.shift_operand_out; v.imm24 = bus.signed_imm_24_out;
    v.valid = bus.valid_out; v.immd = bus.immd_out; v.b = bus.b_out; v.s = bus.s_out;
    v.wb = bus.wb_en_out; v.mr = bus.mem_r_en_out; v.mw = bus.mem_w_en_out;
    v.cmd = bus.exe_cmd_out; v.dest = bus.dest_out; v.src1 = bus.src1_out;
    v.src2 = bus.src2_out; v.status = bus.status_out;
    return v;
  endfunction

  function automatic f_t get_in();
    f_t v;
    v.pc = bus.pc_in; v.val_rn = bus.val_rn_in; v.val_rm = bus.val_rm_in;
    v.shop = bus.shift_operand_in; v.imm24 = bus.signed_imm_24_in;
    v.valid = bus.valid_in; v.immd = bus.immd_in; v.b = bus.b_in; v.s = bus.s_in;
    v.wb = bus.wb_en_in; v.mr = bus.mem_r_en_in; v.mw = bus.mem_w_en_in;
    v.cmd = bus.exe_cmd_in; v.dest = bus.dest_in; v.src1 = bus.src1_in;
    v.src2 = bus.src2_in; v.status = bus.status_in;
    return v;
  endfunction

  task automatic drive(input f_t v);
    bus.pc_in = v.pc; bus.val_rn_in = v.val_rn; bus.val_rm_in = v.val_rm;
    bus.shift_operand_in = v.shop; bus.signed_imm_24_in = v.imm24;
    bus.valid_in = v.valid; bus.immd_in = v.immd; bus.b_in = v.b; bus.s_in = v.s;
    bus.wb_en_in = v.wb; bus.mem_r_en_in = v.mr; bus.mem_w_en_in = v.mw;
    bus.exe_cmd_in = v.cmd; bus.dest_in = v.dest; bus.src1_in = v.src1;
    bus.src2_in = v.src2; bus.status_in = v.status;
  endtask

  function automatic f_t rnd();
    f_t v;
    v.pc = $urandom; v.val_rn = $urandom; v.val_rm = $urandom;
    v.shop = 12'($urandom); v.imm24 = 24'($urandom);
    v.valid = 1'($urandom); v.immd = 1'($urandom); v.b = 1'($urandom);
    v.s = 1'($urandom); v.wb = 1'($urandom); v.mr = 1'($urandom); v.mw = 1'($urandom);
    v.cmd = 4'($urandom); v.dest = 4'($urandom); v.src1 = 4'($urandom);
    v.src2 = 4'($urandom); v.status = 4'($urandom);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".fields"}, 192'(get_out()), 192'(m));
    chk({tag, ".mem_cmd"}, 192'(bus.mem_cmd_out), 192'(m.mr | m.mw));
    chk({tag, ".stall_cnt"}, 192'(stall_cnt), 192'(m_stall));
    chk({tag, ".bubble_cnt"}, 192'(bubble_cnt), 192'(m_bub));
  endtask

  // Apply one clock edge: predict from the rules, step, then compare.
  task automatic tick(input string tag);
    f_t nxt;
    if (freeze)     nxt = m;
    else if (flush) nxt = '0;
    else            nxt = get_in();
`ifdef ID_EXE_STATS_EN
    if (stats_clr) begin
      m_stall = '0; m_bub = '0;
    end else begin
      if (freeze && m_stall != SAT) m_stall = m_stall + 1'b1;
      if (!freeze && (flush || !bus.valid_in) && m_bub != SAT) m_bub = m_bub + 1'b1;
    end
`endif
    @(posedge clk);
    #1;
    m = nxt;
    check_all(tag);
  endtask

  initial begin
    f_t v;
    m = '0; m_stall = '0; m_bub = '0;
    drive(rnd());
    #2;
    check_all("reset_hold");
    @(posedge clk); #1;
    check_all("reset_edge");
    @(negedge clk);
    rst = 1'b1;

    // Reset then capture
    v = '0; v.val_rm = 32'hDEADBEEF; v.shop = 12'h3A5; v.wb = 1'b1; v.valid = 1'b1;
    drive(v);
    tick("capture");
    chk("capture.val_rm", 192'(bus.val_rm_out), 192'(32'hDEADBEEF));
    chk("capture.shop", 192'(bus.shift_operand_out), 192'(12'h3A5));

    // Freeze hold for 3 edges
    stats_clr = 1'b1; v = '0; v.valid = 1'b1; v.pc = 32'h40; drive(v);
    tick("freeze_load");
    stats_clr = 1'b0; freeze = 1'b1; v.pc = 32'h44; drive(v);
    for (int i = 0; i < 3; i++) begin
      tick("freeze_hold");
      chk("freeze_hold.pc", 192'(bus.pc_out), 192'(32'h40));
    end
`ifdef ID_EXE_STATS_EN
    chk("freeze_hold.stall3", 192'(stall_cnt), 192'(3));
`endif
    freeze = 1'b0;
    tick("freeze_release");
    chk("freeze_release.pc", 192'(bus.pc_out), 192'(32'h44));

    // Flush bubble
    stats_clr = 1'b1; v = rnd(); v.valid = 1'b1; v.mw = 1'b1; v.dest = 4'd5; drive(v);
    tick("flush_load");
    stats_clr = 1'b0; flush = 1'b1; drive(rnd());
    tick("flush_bubble");
    chk("flush_bubble.mem_cmd", 192'(bus.mem_cmd_out), 192'(0));
    flush = 1'b0;

    // Freeze and flush together: freeze wins
    v = rnd(); v.valid = 1'b1; v.cmd = 4'b0010; drive(v);
    tick("ff_load");
    freeze = 1'b1; flush = 1'b1; drive(rnd());
    tick("ff_both");
    chk("ff_both.exe_cmd", 192'(bus.exe_cmd_out), 192'(4'b0010));
    freeze = 1'b0; flush = 1'b0;

    // Async reset while frozen with nonzero state
    v = rnd(); v.pc = 32'h1234_5678; drive(v);
    tick("arst_load");
    freeze = 1'b1;
    #2 rst = 1'b0;
    #1;
    m = '0; m_stall = '0; m_bub = '0;
    check_all("arst_mid");
    #1 rst = 1'b1;
    tick("arst_hold");

    // Stall counter saturation, then clear beating an increment
    for (int i = 0; i < 20; i++) tick("sat");
`ifdef ID_EXE_STATS_EN
    chk("sat.stall15", 192'(stall_cnt), 192'(15));
`endif
    stats_clr = 1'b1;
    tick("sat_clr");
    stats_clr = 1'b0; freeze = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      v = rnd();
      v.valid = ($urandom_range(0, 9) < 8);
      drive(v);
      freeze    = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 6) == 0);
      stats_clr = ($urandom_range(0, 39) == 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
